// File: rtl/daq_spi_pkg.sv
// Shared types and constants for the DAQ 3-wire SPI bridge.
//   spi_state_e : bridge FSM state encoding
//   SPI_RW_READ : value of the instruction's first bit that selects a read
//   cnt_width() : width of the instruction bit counter
package daq_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INSTR,
    WDATA,
    RDATA,
    ABORT
  } spi_state_e;

  localparam logic SPI_RW_READ = 1'b1;

  // Counter must be able to hold INSTR_BITS itself, since it saturates there.
  function automatic int cnt_width(input int instr_bits);
    return $clog2(instr_bits + 1);
  endfunction

endpackage

// File: rtl/daq_spi_3wire_bridge_if.sv
// Pin bundle of the 3-wire SPI bridge.
//   spi_csn/spi_clk/spi_mosi/spi_miso : 4-wire side toward the PS SPI master
//   sdio_i/sdio_o/sdio_t              : shared bidirectional SDIO pad (t=1 released)
//   busy/rd_active/err_multi_cs       : status toward the fabric
// slave modport is the bridge's view, master modport is the PS/pad side.
interface daq_spi_3wire_bridge_if #(
  parameter int NUM_CS = 2
);

  logic [NUM_CS-1:0] spi_csn;
  logic              spi_clk;
  logic              spi_mosi;
  logic              spi_miso;
  logic              sdio_i;
  logic              sdio_o;
  logic              sdio_t;
  logic              busy;
  logic              rd_active;
  logic              err_multi_cs;

  modport slave (
    input  spi_csn, spi_clk, spi_mosi, sdio_i,
    output spi_miso, sdio_o, sdio_t, busy, rd_active, err_multi_cs
  );

  modport master (
    output spi_csn, spi_clk, spi_mosi, sdio_i,
    input  spi_miso, sdio_o, sdio_t, busy, rd_active, err_multi_cs
  );

endinterface

// File: rtl/daq_sync_edge.sv
// STAGES-deep synchroniser for a WIDTH-bit input, with optional per-bit
// rise/fall pulses derived from the synchronised value.
//   clk, resetn : fabric clock, async active-low reset
//   d           : asynchronous input
//   q           : synchronised output (reset value RST_VAL on every bit)
//   rise, fall  : one-cycle pulses on q edges (tied low when EDGE_EN=0)
module daq_sync_edge #(
  parameter int   WIDTH   = 1,
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0,
  parameter bit   EDGE_EN = 1'b1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] sync_r [STAGES];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < STAGES; i++) sync_r[i] <= {WIDTH{RST_VAL}};
    end else begin
      sync_r[0] <= d;
      for (int i = 1; i < STAGES; i++) sync_r[i] <= sync_r[i-1];
    end
  end

  assign q = sync_r[STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic [WIDTH-1:0] prev_r;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) prev_r <= {WIDTH{RST_VAL}};
        else         prev_r <= q;
      end

      assign rise = q & ~prev_r;
      assign fall = ~q & prev_r;
    end else begin : g_no_edge
      assign rise = '0;
      assign fall = '0;
    end
  endgenerate

endmodule

// File: rtl/daq_spi_3wire_bridge.sv
// 3-wire SPI bridge: oversamples the PS 4-wire SPI pins in the clk domain,
// drives SDIO during the instruction and write phases, and releases SDIO
// for the read data phase when the instruction's R/W bit selects a read.
// Illegal multi-select patterns abort the transaction with a one-cycle flag.
//   clk, resetn : fabric clock (>= 8x SPI clock), async active-low reset
//   bus         : slave view of daq_spi_3wire_bridge_if (SPI pins, SDIO pad, status)
//   xfer_cnt    : completed-transfer count, only with DAQ_SPI_XFER_CNT_EN defined
//
// state | meaning
// IDLE  | no chip select low, SDIO released
// INSTR | shifting instruction, bridge drives SDIO from mosi
// WDATA | write data phase, bridge drives SDIO from mosi
// RDATA | read data phase, SDIO released, pad data returned on miso
// ABORT | illegal select seen, SDIO released until all csn high
module daq_spi_3wire_bridge
  import daq_spi_pkg::*;
#(
  parameter int NUM_CS      = 2,
  parameter int INSTR_BITS  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  daq_spi_3wire_bridge_if.slave bus
`ifdef DAQ_SPI_XFER_CNT_EN
  ,
  output logic [15:0] xfer_cnt
`endif
);

  localparam int            CW      = cnt_width(INSTR_BITS);
  localparam logic [CW-1:0] BIT_MAX = CW'(INSTR_BITS);

  logic [NUM_CS-1:0] csn_s, cs_low, csn_rise_unused, csn_fall_unused;
  logic              mosi_s, mosi_rise_unused, mosi_fall_unused;
  logic              sclk_s_unused, sclk_rise, sclk_fall;
  logic              cs_any, cs_multi, cs_changed;

  spi_state_e        state;
  logic [CW-1:0]     bit_cnt;
  logic              rw;
  logic [NUM_CS-1:0] cs_sel;
  logic              sdio_o_r, sdio_t_r, miso_r, busy_r, rd_active_r, err_r;

  // Chip selects idle high, so their synchroniser resets to all ones.
  daq_sync_edge #(.WIDTH(NUM_CS), .STAGES(SYNC_STAGES), .RST_VAL(1'b1), .EDGE_EN(1'b0)) u_sync_csn (
    .clk(clk), .resetn(resetn), .d(bus.spi_csn),
    .q(csn_s), .rise(csn_rise_unused), .fall(csn_fall_unused)
  );

  daq_sync_edge #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGE_EN(1'b1)) u_sync_sclk (
    .clk(clk), .resetn(resetn), .d(bus.spi_clk),
    .q(sclk_s_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  daq_sync_edge #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGE_EN(1'b0)) u_sync_mosi (
    .clk(clk), .resetn(resetn), .d(bus.spi_mosi),
    .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  assign cs_low     = ~csn_s;
  assign cs_any     = |cs_low;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign cs_multi   = |(cs_low & (cs_low - NUM_CS'(1)));
  assign cs_changed = (csn_s != cs_sel);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      rw          <= 1'b0;
      cs_sel      <= '1;
      sdio_o_r    <= 1'b0;
      sdio_t_r    <= 1'b1;
      miso_r      <= 1'b0;
      busy_r      <= 1'b0;
      rd_active_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      err_r  <= 1'b0;
      miso_r <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (cs_multi) begin
            state  <= ABORT;
            busy_r <= 1'b1;
            err_r  <= 1'b1;
          end else if (cs_any) begin
            state    <= INSTR;
            cs_sel   <= csn_s;
            busy_r   <= 1'b1;
            sdio_t_r <= 1'b0;
            sdio_o_r <= mosi_s;
          end
        end
        ABORT: begin
          if (!cs_any) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end
        end
        default: begin
          // Deselect takes priority over any SCLK edge seen in the same cycle.
          if (!cs_any) begin
            state       <= IDLE;
            busy_r      <= 1'b0;
            sdio_t_r    <= 1'b1;
            sdio_o_r    <= 1'b0;
            rd_active_r <= 1'b0;
          end else if (cs_multi || cs_changed) begin
            state       <= ABORT;
            err_r       <= 1'b1;
            sdio_t_r    <= 1'b1;
            sdio_o_r    <= 1'b0;
            rd_active_r <= 1'b0;
          end else begin
            case (state)
              INSTR: begin
                sdio_o_r <= mosi_s;
                if (sclk_rise) begin
                  if (bit_cnt == '0)     rw      <= mosi_s;
                  if (bit_cnt != BIT_MAX) bit_cnt <= bit_cnt + CW'(1);
                end
                // Turn around only on the fall after the last instruction bit,
                // so SDIO is never released in the middle of a bit.
                if (sclk_fall && bit_cnt == BIT_MAX) begin
                  if (rw == SPI_RW_READ) begin
                    state       <= RDATA;
                    sdio_t_r    <= 1'b1;
                    sdio_o_r    <= 1'b0;
                    rd_active_r <= 1'b1;
                  end else begin
                    state <= WDATA;
                  end
                end
              end
              WDATA:   sdio_o_r <= mosi_s;
              RDATA:   miso_r   <= bus.sdio_i;
              default: ;
            endcase
          end
        end
      endcase
    end
  end

`ifdef DAQ_SPI_XFER_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) xfer_cnt <= '0;
    else if ((state == INSTR || state == WDATA || state == RDATA) && !cs_any)
      xfer_cnt <= xfer_cnt + 16'd1;
  end
`endif

  assign bus.sdio_o       = sdio_o_r;
  assign bus.sdio_t       = sdio_t_r;
  assign bus.spi_miso     = miso_r;
  assign bus.busy         = busy_r;
  assign bus.rd_active    = rd_active_r;
  assign bus.err_multi_cs = err_r;

endmodule

// File: tb/tb_daq_spi_3wire_bridge.sv
module tb_daq_spi_3wire_bridge;

  localparam int HP = 8;  // SPI half period in clk cycles

  logic       clk = 1'b0;
  logic       resetn;
  logic [1:0] csn_a;
  logic [3:0] csn_b;
  logic       sclk, mosi, sdio_in;
  bit         use_b, mon_en;

  int n_pass = 0;
  int n_total = 0;
  int err_seen = 0;

  always #5 clk = ~clk;

  daq_spi_3wire_bridge_if #(.NUM_CS(2)) if_a ();
  daq_spi_3wire_bridge_if #(.NUM_CS(4)) if_b ();

  assign if_a.spi_csn  = csn_a;
  assign if_a.spi_clk  = sclk;
  assign if_a.spi_mosi = mosi;
  assign if_a.sdio_i   = sdio_in;
  assign if_b.spi_csn  = csn_b;
  assign if_b.spi_clk  = sclk;
  assign if_b.spi_mosi = mosi;
  assign if_b.sdio_i   = sdio_in;

`ifdef DAQ_SPI_XFER_CNT_EN
  logic [15:0] xcnt_a, xcnt_b;
  daq_spi_3wire_bridge #(.NUM_CS(2), .INSTR_BITS(16), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .resetn(resetn), .bus(if_a.slave), .xfer_cnt(xcnt_a));
  daq_spi_3wire_bridge #(.NUM_CS(4), .INSTR_BITS(8), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .resetn(resetn), .bus(if_b.slave), .xfer_cnt(xcnt_b));
`else
  daq_spi_3wire_bridge #(.NUM_CS(2), .INSTR_BITS(16), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .resetn(resetn), .bus(if_a.slave));
  daq_spi_3wire_bridge #(.NUM_CS(4), .INSTR_BITS(8), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .resetn(resetn), .bus(if_b.slave));
`endif

  logic sel_t, sel_o, sel_miso, sel_busy, sel_rd, sel_err;
  assign sel_t    = use_b ? if_b.sdio_t       : if_a.sdio_t;
  assign sel_o    = use_b ? if_b.sdio_o       : if_a.sdio_o;
  assign sel_miso = use_b ? if_b.spi_miso     : if_a.spi_miso;
  assign sel_busy = use_b ? if_b.busy         : if_a.busy;
  assign sel_rd   = use_b ? if_b.rd_active    : if_a.rd_active;
  assign sel_err  = use_b ? if_b.err_multi_cs : if_a.err_multi_cs;

  // Per SCLK rise: {sdio_t, rd_active, data bit seen by the receiver}
  typedef struct packed {
    logic t;
    logic ra;
    logic v;
  } obs_t;
  obs_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  initial begin
    forever begin
      @(posedge sclk);
      if (mon_en) begin
        obs_t got, e;
        got = '{t: sel_t, ra: sel_rd, v: (sel_t ? sel_miso : sel_o)};
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL bit_unexpected: got %0h with no expected entry at %0t", got, $time);
        end else begin
          e = exp_q.pop_front();
          check("sclk_bit", 32'(got), 32'(e));
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (sel_err === 1'b1) err_seen++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cs(input int cs, input logic v);
    if (use_b) csn_b[cs] = v;
    else       csn_a[cs] = v;
  endtask

  task automatic end_cs();
    csn_a   = '1;
    csn_b   = '1;
    sdio_in = 1'b0;
    tick(2);
    check("busy_before_csn_rise_sync", 32'(sel_busy), 32'd1);
    tick(1);
    check("busy_after_csn_rise", 32'(sel_busy), 32'd0);
    check("sdio_t_after_csn_rise", 32'(sel_t), 32'd1);
  endtask

  task automatic spi_xfer(input int cs, input int n_instr, input int n_bits,
                          input logic [31:0] tx, input logic [7:0] rx,
                          input bit rd, input bit finish);
    set_cs(cs, 1'b0);
    tick(2);
    check("busy_before_csn_fall_sync", 32'(sel_busy), 32'd0);
    tick(1);
    check("busy_after_csn_fall", 32'(sel_busy), 32'd1);
    tick(HP - 3);
    for (int i = 0; i < n_bits; i++) begin
      sclk = 1'b0;
      if (rd && i >= n_instr) begin
        mosi    = 1'b0;
        sdio_in = rx[n_bits-1-i];
        exp_q.push_back('{t: 1'b1, ra: 1'b1, v: rx[n_bits-1-i]});
      end else begin
        mosi = tx[n_bits-1-i];
        exp_q.push_back('{t: 1'b0, ra: 1'b0, v: tx[n_bits-1-i]});
      end
      tick(HP);
      sclk = 1'b1;
      tick(HP);
    end
    sclk = 1'b0;
    tick(HP);
    if (finish) end_cs();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sdio_t"},  32'(sel_t),    32'd1);
    check({tag, "_sdio_o"},  32'(sel_o),    32'd0);
    check({tag, "_miso"},    32'(sel_miso), 32'd0);
    check({tag, "_busy"},    32'(sel_busy), 32'd0);
    check({tag, "_rd"},      32'(sel_rd),   32'd0);
    check({tag, "_err"},     32'(sel_err),  32'd0);
  endtask

  initial begin
    resetn  = 1'b0;
    csn_a   = '1;
    csn_b   = '1;
    sclk    = 1'b0;
    mosi    = 1'b0;
    sdio_in = 1'b0;
    use_b   = 1'b0;
    mon_en  = 1'b0;
    tick(3);
    check_reset_outputs("rst_a");
`ifdef DAQ_SPI_XFER_CNT_EN
    check("rst_xfer_cnt", 32'(xcnt_a), 32'd0);
`endif
    resetn = 1'b1;
    tick(3);
    mon_en = 1'b1;

    // Write: instruction 0x0014 then data 0xA5 via csn[1]
    spi_xfer(1, 16, 24, 32'h0014A5, 8'h00, 1'b0, 1'b1);
`ifdef DAQ_SPI_XFER_CNT_EN
    check("xfer_cnt_after_write", 32'(xcnt_a), 32'd1);
`endif

    // Read: instruction 0x8001, device returns 0x3C
    spi_xfer(1, 16, 24, 32'h800100, 8'h3C, 1'b1, 1'b1);
`ifdef DAQ_SPI_XFER_CNT_EN
    check("xfer_cnt_after_read", 32'(xcnt_a), 32'd2);
`endif

    // Multi-select in the middle of the instruction
    spi_xfer(1, 16, 6, 32'h2A, 8'h00, 1'b0, 1'b0);
    err_seen = 0;
    csn_a = 2'b00;
    tick(10);
    check("abort_err_pulses", 32'(err_seen), 32'd1);
    check("abort_sdio_t", 32'(sel_t), 32'd1);
    check("abort_busy", 32'(sel_busy), 32'd1);
    check("abort_rd_active", 32'(sel_rd), 32'd0);
    csn_a = 2'b10;
    tick(10);
    check("abort_hold_busy", 32'(sel_busy), 32'd1);
    check("abort_hold_sdio_t", 32'(sel_t), 32'd1);
    check("abort_no_second_err", 32'(err_seen), 32'd1);
    csn_a = 2'b11;
    tick(3);
    check("abort_exit_busy", 32'(sel_busy), 32'd0);
`ifdef DAQ_SPI_XFER_CNT_EN
    check("xfer_cnt_after_abort", 32'(xcnt_a), 32'd2);
`endif

    // Short transfer then a full read: turnaround must still land after bit 16
    spi_xfer(0, 16, 5, 32'h16, 8'h00, 1'b0, 1'b1);
    spi_xfer(0, 16, 24, 32'h800100, 8'h96, 1'b1, 1'b1);
`ifdef DAQ_SPI_XFER_CNT_EN
    check("xfer_cnt_after_short", 32'(xcnt_a), 32'd4);
`endif

    // Reset asserted in the read data phase
    spi_xfer(1, 16, 19, {13'd0, 16'h8001, 3'b000}, 8'h05, 1'b1, 1'b0);
    #2 resetn = 1'b0;
    #1 check_reset_outputs("async_rst");
    csn_a   = '1;
    sdio_in = 1'b0;
    tick(3);
    resetn = 1'b1;
    tick(6);
    check("post_rst_idle_busy", 32'(sel_busy), 32'd0);
`ifdef DAQ_SPI_XFER_CNT_EN
    check("post_rst_xfer_cnt", 32'(xcnt_a), 32'd0);
`endif
    spi_xfer(1, 16, 24, 32'h12345A, 8'h00, 1'b0, 1'b1);

    // NUM_CS=4, INSTR_BITS=8 build: read via csn[3], then write via csn[2]
    use_b = 1'b1;
    spi_xfer(3, 8, 16, 32'h8500, 8'hC3, 1'b1, 1'b1);
    spi_xfer(2, 8, 16, 32'h4D66, 8'h00, 1'b0, 1'b1);
`ifdef DAQ_SPI_XFER_CNT_EN
    check("b_xfer_cnt", 32'(xcnt_b), 32'd2);
`endif

    mon_en = 1'b0;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
